// File: rtl/rvecc_scrubber.sv
// rvecc_scrubber: background SEC-DED scrubber for a 39-bit codeword memory.
// Walks addresses 0..DEPTH-1, reads each codeword, writes back corrected
// single-bit errors and counts/logs uncorrectable (double) errors.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, continuous, clear pass control and counter clear
//   mem_req/we/addr/wdata    request side towards the memory arbiter
//   mem_gnt/rvalid/rdata     grant and read response from the memory
//   fn_wr_valid/fn_wr_addr   snoop of functional-port writes
//   busy, done               pass status
//   sec_count, ded_count     saturating error counters
//   ded_valid, ded_addr      sticky first-DED log
module rvecc_scrubber #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned INTERVAL = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              clear,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [38:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [38:0]       mem_rdata,
    input  logic              fn_wr_valid,
    input  logic [ADDR_W-1:0] fn_wr_addr,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sec_count,
    output logic [15:0]       ded_count,
    output logic              ded_valid,
    output logic [ADDR_W-1:0] ded_addr
);
    localparam int unsigned       CNT_W     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {StIdle, StWait, StRead, StResp, StCheck, StWrite, StNext} state_e;

    // Codeword position of data bit k: positions 1..38 minus powers of two.
    function automatic logic [5:0] data_pos(input int k);
        if (k < 1)       return 6'(k + 3);
        else if (k < 4)  return 6'(k + 4);
        else if (k < 11) return 6'(k + 5);
        else if (k < 26) return 6'(k + 6);
        else             return 6'(k + 7);
    endfunction

    // XOR of the positions of all set data bits == check bits ecc[5:0].
    function automatic logic [5:0] calc_syn(input logic [31:0] d);
        logic [5:0] s;
        s = '0;
        for (int k = 0; k < 32; k++) begin
            s = s ^ (d[k] ? data_pos(k) : 6'd0);
        end
        return s;
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [5:0] s;
        s = calc_syn(d);
        return {^{s, d}, s, d};
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [38:0]       rdata_q, rdata_d;
    logic              stale_q, stale_d;
    logic [15:0]       sec_q, sec_d, ded_q, ded_d;
    logic              ded_valid_q, ded_valid_d;
    logic [ADDR_W-1:0] ded_addr_q, ded_addr_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [38:0]       wdata_q, wdata_d;

    logic [5:0]  syndrome;
    logic        parity_err, err_single, err_double;
    logic [31:0] data_fix;
    logic        snoop_hit;

    always_comb begin
        syndrome   = calc_syn(rdata_q[31:0]) ^ rdata_q[37:32];
        parity_err = ^rdata_q;
        data_fix   = rdata_q[31:0];
        for (int k = 0; k < 32; k++) begin
            if (data_pos(k) == syndrome) data_fix[k] = ~data_fix[k];
        end
        // Odd parity with a syndrome outside the code is treated as uncorrectable.
        err_single = parity_err && (syndrome <= 6'd38);
        err_double = !err_single && (parity_err || (syndrome != 6'd0));
    end

    // Window runs from the read grant up to (not including) the write grant.
    assign snoop_hit = fn_wr_valid && (fn_wr_addr == cursor_q) &&
                       ((state_q == StRead && mem_gnt) || state_q == StResp ||
                        state_q == StCheck || (state_q == StWrite && !mem_gnt));

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        wait_d      = wait_q;
        rdata_d     = rdata_q;
        stale_d     = stale_q | snoop_hit;
        sec_d       = sec_q;
        ded_d       = ded_q;
        ded_valid_d = ded_valid_q;
        ded_addr_d  = ded_addr_q;
        done_d      = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWait;
                    wait_d  = '0;
                end
            end
            StWait: begin
                if (wait_q == CNT_LAST) begin
                    state_d = StRead;
                    addr_d  = cursor_q;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StRead: begin
                if (mem_gnt) state_d = StResp;
            end
            StResp: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = StNext;
                if (err_single) begin
                    if (sec_q != 16'hFFFF) sec_d = sec_q + 16'd1;
                    if (!(stale_q || snoop_hit)) begin
                        state_d = StWrite;
                        wdata_d = encode(data_fix);
                        addr_d  = cursor_q;
                    end
                end else if (err_double) begin
                    if (ded_q != 16'hFFFF) ded_d = ded_q + 16'd1;
                    if (!ded_valid_q) begin
                        ded_valid_d = 1'b1;
                        ded_addr_d  = cursor_q;
                    end
                end
            end
            StWrite: begin
                if (mem_gnt || stale_q || snoop_hit) state_d = StNext;
            end
            StNext: begin
                stale_d = 1'b0;
                wait_d  = '0;
                if (cursor_q == ADDR_LAST) begin
                    done_d   = 1'b1;
                    cursor_d = '0;
                    state_d  = continuous ? StWait : StIdle;
                end else begin
                    cursor_d = cursor_q + 1'b1;
                    state_d  = StWait;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            sec_d       = '0;
            ded_d       = '0;
            ded_valid_d = 1'b0;
            ded_addr_d  = '0;
        end

        req_d  = (state_d == StRead) || (state_d == StWrite);
        we_d   = (state_d == StWrite);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cursor_q    <= '0;
            wait_q      <= '0;
            rdata_q     <= '0;
            stale_q     <= 1'b0;
            sec_q       <= '0;
            ded_q       <= '0;
            ded_valid_q <= 1'b0;
            ded_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            wait_q      <= wait_d;
            rdata_q     <= rdata_d;
            stale_q     <= stale_d;
            sec_q       <= sec_d;
            ded_q       <= ded_d;
            ded_valid_q <= ded_valid_d;
            ded_addr_q  <= ded_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sec_count = sec_q;
    assign ded_count = ded_q;
    assign ded_valid = ded_valid_q;
    assign ded_addr  = ded_addr_q;

endmodule

// File: doc/rvecc_scrubber.md
# rvecc_scrubber

Background ECC scrubber for a 39-bit SEC-DED-protected memory (32 data bits plus 7 check bits, same code as `rvecc_encode`/`rvecc_decode`). It walks the array address by address, reads each codeword, corrects single-bit errors and writes the corrected codeword back, and counts and logs double-bit errors. It sits beside the memory's functional port as a low-priority requester. It uses the existing decoder and encoder to check and regenerate codewords.

## Interface
- `DEPTH`, 1024: number of words scrubbed per pass (addresses 0..DEPTH-1).
- `ADDR_W`, 10: address width; must satisfy 2^ADDR_W >= DEPTH.
- `INTERVAL`, 256: idle cycles between consecutive word accesses (>= 1).
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a pass when idle.
- `continuous`  in  1  when 1, a new pass begins automatically after each pass completes.
- `clear`  in  1  synchronous clear of counters and DED log.
- `mem_req`  out  1  access request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  ADDR_W  access address.
- `mem_wdata`  out  39  codeword {ecc[6:0], data[31:0]} for writes.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  39  read codeword {ecc[6:0], data[31:0]}.
- `fn_wr_valid`  in  1  functional port writes this cycle.
- `fn_wr_addr`  in  ADDR_W  address of functional write.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle pulse at pass end.
- `sec_count`  out  16  corrected errors, saturating at 16'hFFFF.
- `ded_count`  out  16  uncorrectable errors, saturating.
- `ded_valid`  out  1  sticky: at least one DED logged.
- `ded_addr`  out  ADDR_W  address of the first DED since the last clear.

## Operation
- Code: positions 1..38, with check bits at positions 1,2,4,8,16,32 and data bits filling the remaining positions in ascending order (data[0] at position 3). ecc[i] (i=0..5) is the XOR of the data bits whose position has bit i set. ecc[6] is the XOR of all data bits and ecc[5:0].
- Decoding uses `rvecc_decode` with `en`=1 and `sed_ded`=0.
- FSM states:
  - IDLE: wait for `start`, or for `continuous` after a pass.
  - WAIT: count INTERVAL cycles, then go to READ.
  - READ: hold `mem_req`=1, `mem_we`=0, `mem_addr`=cursor until `mem_gnt`, then go to RESP.
  - RESP: wait for `mem_rvalid` and register `mem_rdata`, then go to CHECK.
  - CHECK: one cycle.
    - Single error: increment `sec_count` and go to WRITE.
    - Double error: increment `ded_count`; if `ded_valid`=0, set it and load `ded_addr`; go to NEXT.
    - Clean: go to NEXT.
  - WRITE: hold `mem_req`=1, `mem_we`=1, with `mem_wdata` = corrected codeword, until `mem_gnt`, then go to NEXT.
  - NEXT: if cursor == DEPTH-1, pulse `done`, clear cursor and go to IDLE; otherwise increment cursor and go to WAIT.
- Snoop: if `fn_wr_valid` with `fn_wr_addr` == cursor occurs in any cycle from the READ grant through the cycle before the WRITE grant, set `stale`.
  - With `stale`=1, CHECK and WRITE skip the writeback and go to NEXT.
  - `sec_count` still increments.
  - `stale` clears in NEXT.
- Exactly one outstanding read at a time; `mem_req` is never asserted outside READ and WRITE.
- `start` while `busy` is ignored. `continuous` is sampled in NEXT on the last address; if 1, the FSM goes to WAIT instead of IDLE (`done` still pulses).
- `clear` zeroes both counters, `ded_valid` and `ded_addr`. If `clear` coincides with a CHECK increment, `clear` wins (the result is 0). Clearing does not disturb the FSM.

## Timing
- Reset values:
  - FSM = IDLE, cursor = 0.
  - `mem_req`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `busy`=`done`=0, counters=0, `ded_valid`=0, `ded_addr`=0.
- Reset mid-access drops `mem_req` immediately; any in-flight `mem_rvalid` is ignored.
- `busy`=1 from the cycle after `start` until the cycle `done` pulses. It stays 1 in continuous mode.
- All outputs are registered; none depends combinationally on inputs.
- Minimum per-word time with immediate grant and `mem_rvalid` one cycle after grant: INTERVAL + 1 (READ) + 1 (RESP) + 1 (CHECK) + 1 (WRITE, if any) + 1 (NEXT).
- Request outputs stay stable while `mem_gnt`=0. The transfer completes on the cycle `mem_gnt`=1.

## Test plan
- Clean pass: memory preloaded with valid codewords, DEPTH=8, INTERVAL=2, `start` -> 8 reads at addresses 0..7, no writes, `done` pulses once, `sec_count`=`ded_count`=0.
- Single error: address 5 holds data 32'hDEADBEEF encoding with bit 17 flipped -> one write to address 5 of the exact encoding of 32'hDEADBEEF; `sec_count`=1.
- Double error: address 3 with bits 0 and 38 flipped -> no write; `ded_count`=1, `ded_valid`=1, `ded_addr`=3. A later DED at address 6 leaves `ded_addr`=3 and makes `ded_count`=2.
- Snoop race: single error at address 2, plus `fn_wr_valid` to address 2 between the READ grant and the WRITE grant -> no write to address 2; `sec_count`=1.
- Grant stall and reset: `mem_gnt` held low 10 cycles in READ -> `mem_req`/`mem_addr` stable throughout. Asserting `rst` mid-stall -> all outputs go to reset values the same cycle.
- Saturation and clear: force `sec_count` to 16'hFFFF, inject a single error -> stays 16'hFFFF. `clear` -> counters read 0 next cycle.
